// File: rtl/branch_predictor.sv
// Direct-mapped branch history table with a target buffer. It gives a zero-latency taken/target
// prediction at fetch and is trained by resolved conditional branches from execute.
module branch_predictor #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_target,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = XLEN - 2 - IDX_W;

    logic [ENTRIES-1:0]      valid_q;
    logic [ENTRIES-1:0][1:0] ctr_q;
    logic [TAG_W-1:0]        tag_q    [ENTRIES];
    logic [XLEN-1:0]         target_q [ENTRIES];

    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispredict_cnt_q;

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       upd_ctr;
    logic             upd_pc_unused;

    // The PC byte offset never takes part in indexing or tagging.
    assign upd_pc_unused = ^upd_pc[1:0];

    always_comb begin
        fetch_idx   = fetch_pc[IDX_W+1:2];
        fetch_tag   = fetch_pc[XLEN-1:IDX_W+2];
        fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
        pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + XLEN'(4);
    end

    always_comb begin
        upd_idx    = upd_pc[IDX_W+1:2];
        upd_tag    = upd_pc[XLEN-1:IDX_W+2];
        upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_ctr    = ctr_q[upd_idx];
        mispredict = upd_valid &&
                     ((upd_pred_taken != upd_taken) ||
                      (upd_taken && upd_pred_taken && (upd_pred_target != upd_target)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q          <= '0;
            ctr_q            <= {ENTRIES{2'b01}};
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    if (upd_ctr != 2'b11) ctr_q[upd_idx] <= upd_ctr + 2'd1;
                end else begin
                    if (upd_ctr != 2'b00) ctr_q[upd_idx] <= upd_ctr - 2'd1;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= 2'b10;
            end
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispredict && (mispredict_cnt_q != '1))
                mispredict_cnt_q <= mispredict_cnt_q + CNT_W'(1);
        end
    end

    // Tag and target need no reset; any taken resolution leaves this entry owned by upd_pc,
    // either by allocation or because it already hit, so the tag write is harmless on a hit.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor against an array-based reference model that is checked every
// cycle, plus hand-computed literal expectations along the training/alias/hazard/reset/saturation walk.
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 5;
    localparam int ENTRIES = 16;
    localparam int CMAX    = 31;

    logic             clk = 1'b0;
    logic             rst;
    logic [XLEN-1:0]  fetch_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_target;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 1'b0;

    branch_predictor #(.XLEN(XLEN), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .mispredict(mispredict),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays with integer counters.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_bcnt;
    int          m_mcnt;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc >> (2 + IDX_W);
    endfunction

    function automatic void model_pred(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        int i;
        i   = idx_of(pc);
        t   = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= 2);
        tgt = t ? m_tgt[i] : pc + 32'd4;
    endfunction

    function automatic logic model_mis();
        if (!upd_valid) return 1'b0;
        if (upd_pred_taken != upd_taken) return 1'b1;
        return upd_taken && (upd_pred_target != upd_target);
    endfunction

    always @(posedge clk) begin
        int  i;
        bit  hit;
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
            m_bcnt = 0;
            m_mcnt = 0;
        end else if (upd_valid) begin
            if (model_mis() && m_mcnt < CMAX) m_mcnt = m_mcnt + 1;
            if (m_bcnt < CMAX) m_bcnt = m_bcnt + 1;
            i   = idx_of(upd_pc);
            hit = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
            if (hit && upd_taken) begin
                m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_tgt[i] = upd_target;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end else if (upd_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(upd_pc);
                m_tgt[i]   = upd_target;
                m_ctr[i]   = 2;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic        et;
        logic [31:0] etgt;
        if (started) begin
            model_pred(fetch_pc, et, etgt);
            chk("cyc_pred_taken", 32'(pred_taken), 32'(et));
            chk("cyc_pred_target", pred_target, etgt);
            chk("cyc_mispredict", 32'(mispredict), 32'(model_mis()));
            chk("cyc_branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
            chk("cyc_mispredict_cnt", 32'(mispredict_cnt), 32'(m_mcnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = t;
        upd_target      = tgt;
        upd_pred_taken  = pt;
        upd_pred_target = ptgt;
    endtask

    task automatic idle();
        upd_valid = 1'b0;
    endtask

    task automatic chk_pred(input string name, input logic t, input logic [31:0] tgt);
        chk({name, "_taken"}, 32'(pred_taken), 32'(t));
        chk({name, "_target"}, pred_target, tgt);
    endtask

    task automatic chk_cnt(input string name, input int b, input int m);
        chk({name, "_branch_cnt"}, 32'(branch_cnt), 32'(b));
        chk({name, "_mispredict_cnt"}, 32'(mispredict_cnt), 32'(m));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        mt;
        logic [31:0] mtgt;
        rst = 1'b1;
        fetch_pc = 32'h100;
        idle();
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_pred_taken = 1'b0; upd_pred_target = '0;
        tick();
        tick();
        rst = 1'b0;
        started = 1'b1;
        #1;
        chk_pred("reset", 1'b0, 32'h104);
        chk_cnt("reset", 0, 0);

        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        #1 chk("alloc_mispredict", 32'(mispredict), 32'd1);
        tick();
        idle();
        #1;
        chk_pred("alloc", 1'b1, 32'h80);
        chk_cnt("alloc", 1, 1);
        model_pred(32'h100, mt, mtgt);
        chk("model_pin_taken", 32'(mt), 32'd1);
        chk("model_pin_target", mtgt, 32'h80);

        upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
        #1 chk("correct_taken_mispredict", 32'(mispredict), 32'd0);
        tick();
        tick();
        idle();
        #1 chk_pred("ctr3", 1'b1, 32'h80);

        upd(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #1 chk("nt_mispredict", 32'(mispredict), 32'd1);
        tick();
        tick();
        upd(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        tick();
        idle();
        #1 chk_pred("ctr0", 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h80, 1'b0, 32'h104);
        tick();
        tick();
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        tick();
        idle();
        #1;
        chk_pred("ctr1", 1'b0, 32'h104);
        chk_cnt("train", 9, 4);

        fetch_pc = 32'h140;
        #1 chk_pred("alias_before", 1'b0, 32'h144);
        upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
        tick();
        idle();
        fetch_pc = 32'h100;
        #1 chk_pred("alias_evicted", 1'b0, 32'h104);
        fetch_pc = 32'h140;
        #1 chk_pred("alias_owner", 1'b1, 32'h300);

        fetch_pc = 32'h200;
        upd(32'h200, 1'b1, 32'h40, 1'b0, 32'h204);
        #1 chk_pred("hazard_same", 1'b0, 32'h204);
        tick();
        idle();
        #1 chk_pred("hazard_next", 1'b1, 32'h40);
        upd(32'h200, 1'b0, 32'h40, 1'b1, 32'h40);
        #1 chk_pred("hazard_nt_same", 1'b1, 32'h40);
        tick();
        idle();
        #1 chk_pred("hazard_nt_next", 1'b0, 32'h204);

        fetch_pc = 32'h104;
        upd(32'h104, 1'b1, 32'h10, 1'b0, 32'h108);
        tick();
        upd(32'h104, 1'b1, 32'h20, 1'b1, 32'h10);
        #1 chk("target_mispredict", 32'(mispredict), 32'd1);
        tick();
        idle();
        #1;
        chk_pred("target_update", 1'b1, 32'h20);
        chk_cnt("pre_reset", 14, 9);

        fetch_pc = 32'hFFFF_FFFC;
        #1 chk_pred("wrap", 1'b0, 32'h0);

        fetch_pc = 32'h104;
        rst = 1'b1;
        upd(32'h104, 1'b1, 32'h20, 1'b1, 32'h20);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk_pred("reset_drop", 1'b0, 32'h108);
        chk_cnt("reset_drop", 0, 0);

        for (int i = 0; i < 31; i++) begin
            upd(32'h300, 1'b0, 32'h0, 1'b1, 32'h304);
            tick();
        end
        idle();
        #1 chk_cnt("sat_reach", 31, 31);
        for (int i = 0; i < 4; i++) begin
            upd(32'h300, 1'b0, 32'h0, 1'b1, 32'h304);
            tick();
        end
        idle();
        #1;
        chk_cnt("sat_hold", 31, 31);
        chk("model_pin_bcnt", 32'(m_bcnt), 32'd31);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch history table with target buffer. Predicts, at fetch, the taken/not-taken decision that the execute-stage branch resolver produces later.
- Fetch side gets a combinational prediction for the current PC.
- Execute side returns the resolved outcome (resolver's pcsrc plus computed target) to train the table and count mispredictions.
- Sits between the PC register and the branch resolver in the RV32I core.

Parameters:
- XLEN, 32, address/PC width
- IDX_W, 4, index bits; table depth ENTRIES = 2**IDX_W
- CNT_W, 32, width of the performance counters

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous active-high reset
- fetch_pc  input  XLEN  PC being fetched this cycle
- pred_taken  output  1  predicted taken for fetch_pc
- pred_target  output  XLEN  predicted next PC
- upd_valid  input  1  resolved conditional branch (beq/bne/blt) presented this cycle
- upd_pc  input  XLEN  PC of the resolved branch
- upd_taken  input  1  resolved outcome (resolver pcsrc)
- upd_target  input  XLEN  computed branch target
- upd_pred_taken  input  1  prediction that was issued for this branch, carried down the pipe
- upd_pred_target  input  XLEN  predicted target that was issued, carried down the pipe
- mispredict  output  1  combinational: upd_valid and the prediction was wrong
- branch_cnt  output  CNT_W  resolved branch count
- mispredict_cnt  output  CNT_W  misprediction count

Behaviour:
- Entry fields: valid (1), tag (XLEN-2-IDX_W, = pc[XLEN-1:IDX_W+2]), ctr (2-bit saturating), target (XLEN).
- Index is pc[IDX_W+1:2]. PC bits [1:0] are ignored.

Reset (rst high at a clock edge):
- All valid bits cleared; all ctr set to 2'b01.
- branch_cnt and mispredict_cnt set to 0.
- Targets and tags are don't-care.
- Outputs after reset: pred_taken=0, pred_target=fetch_pc+4, mispredict follows its equation.
- Reset overrides any simultaneous upd_valid; the update is dropped.

Lookup (combinational, zero latency):
- hit = valid[idx] and tag match.
- pred_taken = hit & ctr[1].
- pred_target = stored target if pred_taken, else fetch_pc+4. The +4 wraps modulo 2^XLEN.

Update (registered, when upd_valid and not rst):
- Hit, taken: ctr saturating increment (3 stays 3); target overwritten with upd_target.
- Hit, not taken: ctr saturating decrement (0 stays 0); target unchanged.
- Miss, taken: allocate the entry: valid=1, new tag, target=upd_target, ctr=2'b10. Evicts any aliasing entry.
- Miss, not taken: no change.
- Updated entry is visible to lookups from the next cycle. A same-cycle lookup of the same index sees the old contents (no bypass).

Misprediction and counters:
- mispredict = upd_valid & ((upd_pred_taken != upd_taken) | (upd_taken & upd_pred_taken & (upd_pred_target != upd_target))).
- On each upd_valid: branch_cnt += 1; mispredict_cnt += 1 if mispredict.
- Both counters saturate at all-ones and never wrap.
- upd_valid=0: no state change.

Test Plan:
- Reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104; both counters 0.
- Update pc=0x100, taken=1, target=0x80, pred_taken=0 -> mispredict=1. Next cycle fetch 0x100 gives pred_taken=1, pred_target=0x80; branch_cnt=1, mispredict_cnt=1.
- Training sequence on pc=0x100:
  - Two more taken updates -> ctr=3.
  - Three not-taken updates -> ctr=0, pred_taken=0.
  - Further not-taken updates -> ctr stays 0.
  - One taken update -> ctr=1, still predicts not-taken.
- Alias: with pc=0x100 allocated, taken update at pc=0x140 (IDX_W=4, same index, different tag):
  - Before the update: fetch 0x140 misses -> pred_target=0x144.
  - After: entry owned by 0x140; fetch 0x100 misses -> pred_target=0x104.
- Same-cycle hazard: update pc=0x200 taken while fetch_pc=0x200 -> that cycle pred_taken=0; next cycle pred_taken=1.
- Reset asserted together with upd_valid on a trained entry -> next cycle the entry misses and both counters are 0. Also preload branch_cnt near all-ones and confirm it saturates.
